// File: rtl/spi_simple_master_if.sv
// Host-side byte stream between a controller and spi_simple_master.
// The DUT attaches through the slave modport; the controller uses master.
interface spi_simple_master_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;

   modport master (
      output tx_data, tx_valid, tx_last,
      input  tx_ready, rx_data, rx_valid, busy
   );

   modport slave (
      input  tx_data, tx_valid, tx_last,
      output tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_simple_master.sv
// Byte-oriented SPI mode-0 initiator (MSB first) fed by a valid/ready byte stream.
// Optional SPI_MASTER_CS_IDLE_EN stretches cs_n-high time between transactions to CS_IDLE cycles.
module spi_simple_master #(
   parameter int DIV     = 2,
   parameter int CS_IDLE = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  spi_clk_o,
   output logic                  spi_mosi_o,
   input  logic                  spi_miso_i,
   output logic                  spi_cs_n_o,
   spi_simple_master_if.slave    host_if
);

   localparam int CNT_MAX = (DIV > CS_IDLE) ? DIV : CS_IDLE;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(DIV - 1);
`ifdef SPI_MASTER_CS_IDLE_EN
   // Guard plus the one IDLE cycle before the next accept keeps cs_n high CS_IDLE cycles.
   localparam int GUARD_CYC = CS_IDLE - 1;
   localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC - 1);
`endif

   typedef enum logic [2:0] {
      IDLE, SETUP, SCK_HI, SCK_LO, HOLD, END
`ifdef SPI_MASTER_CS_IDLE_EN
      , GUARD
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic             last_q, last_d;
   logic             cs_n_q, cs_n_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q, busy_d;
   logic [7:0]       rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic [7:0]       tx_sh_q, tx_sh_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic             accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         last_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         sck_q      <= 1'b0;
         mosi_q     <= 1'b0;
         tx_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         last_q     <= last_d;
         cs_n_q     <= cs_n_d;
         sck_q      <= sck_d;
         mosi_q     <= mosi_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // Shift registers are always fully refilled before use, so they need no reset.
   always_ff @(posedge clk) begin
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      last_d     = last_q;
      cs_n_d     = cs_n_q;
      sck_d      = sck_q;
      mosi_d     = mosi_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      accept     = host_if.tx_valid && tx_ready_q;

      case (state_q)
         IDLE, HOLD: begin
            if (accept) begin
               state_d = SETUP;
               cnt_d   = HALF_LD;
               cs_n_d  = 1'b0;
               sck_d   = 1'b0;
               mosi_d  = host_if.tx_data[7];
               tx_sh_d = {host_if.tx_data[6:0], 1'b0};
               last_d  = host_if.tx_last;
            end
         end
         SETUP, SCK_LO: begin
            if (cnt_q == '0) begin
               state_d = SCK_HI;
               cnt_d   = HALF_LD;
               sck_d   = 1'b1;
               rx_sh_d = {rx_sh_q[6:0], spi_miso_i};
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SCK_HI: begin
            if (cnt_q == '0) begin
               sck_d = 1'b0;
               cnt_d = HALF_LD;
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  rx_data_d  = rx_sh_q;
                  rx_valid_d = 1'b1;
                  state_d    = last_q ? END : HOLD;
               end else begin
                  state_d = SCK_LO;
                  mosi_d  = tx_sh_q[7];
                  tx_sh_d = {tx_sh_q[6:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         END: begin
            if (cnt_q == '0) begin
               cs_n_d = 1'b1;
               mosi_d = 1'b0;
`ifdef SPI_MASTER_CS_IDLE_EN
               if (GUARD_CYC > 0) begin
                  state_d = GUARD;
                  cnt_d   = GUARD_LD;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef SPI_MASTER_CS_IDLE_EN
         GUARD: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase

      // Ready is withheld for the first IDLE cycle after END so cs_n stays high at least two cycles.
      tx_ready_d = (state_d == HOLD) || ((state_d == IDLE) && (state_q != END));
      busy_d     = (state_d != IDLE);
   end

   assign spi_clk_o        = sck_q;
   assign spi_mosi_o       = mosi_q;
   assign spi_cs_n_o       = cs_n_q;
   assign host_if.tx_ready = tx_ready_q;
   assign host_if.rx_data  = rx_data_q;
   assign host_if.rx_valid = rx_valid_q;
   assign host_if.busy     = busy_q;

endmodule

// File: tb/tb_spi_simple_master.sv
// Directed bench for spi_simple_master: a DIV=2 instance (loopback / tied / pattern responder)
// and a DIV=1 instance, observed through one waveform monitor selected by sel.
module tb_spi_simple_master;

`ifdef SPI_MASTER_CS_IDLE_EN
   localparam int EXP_GAP = 4;
`else
   localparam int EXP_GAP = 2;
`endif
   localparam int LIMIT = 2000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   spi_simple_master_if hif2 ();
   spi_simple_master_if hif1 ();

   logic       sel;
   logic [7:0] d_data;
   logic       d_valid, d_last;
   logic [1:0] miso_mode;
   logic [7:0] slv_pat;
   logic [7:0] slv_bits;

   logic sck2, mosi2, miso2, cs2;
   logic sck1, mosi1, cs1;

   assign hif2.tx_data  = d_data;
   assign hif2.tx_last  = d_last;
   assign hif2.tx_valid = d_valid & ~sel;
   assign hif1.tx_data  = d_data;
   assign hif1.tx_last  = d_last;
   assign hif1.tx_valid = d_valid & sel;

   assign miso2 = (miso_mode == 2'd0) ? mosi2 :
                  (miso_mode == 2'd1) ? 1'b0  : slv_pat[~slv_bits[2:0]];

   always @(negedge sck2 or posedge cs2) begin
      if (cs2) slv_bits <= 8'd0;
      else     slv_bits <= slv_bits + 8'd1;
   end

   spi_simple_master #(.DIV(2), .CS_IDLE(4)) dut2 (
      .clk(clk), .rst(rst), .spi_clk_o(sck2), .spi_mosi_o(mosi2),
      .spi_miso_i(miso2), .spi_cs_n_o(cs2), .host_if(hif2)
   );

   spi_simple_master #(.DIV(1), .CS_IDLE(4)) dut1 (
      .clk(clk), .rst(rst), .spi_clk_o(sck1), .spi_mosi_o(mosi1),
      .spi_miso_i(1'b0), .spi_cs_n_o(cs1), .host_if(hif1)
   );

   logic       m_sck, m_mosi, m_cs_n, m_ready, m_busy, m_rxv;
   logic [7:0] m_rxd;
   assign m_sck   = sel ? sck1 : sck2;
   assign m_mosi  = sel ? mosi1 : mosi2;
   assign m_cs_n  = sel ? cs1 : cs2;
   assign m_ready = sel ? hif1.tx_ready : hif2.tx_ready;
   assign m_busy  = sel ? hif1.busy : hif2.busy;
   assign m_rxv   = sel ? hif1.rx_valid : hif2.rx_valid;
   assign m_rxd   = sel ? hif1.rx_data : hif2.rx_data;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Waveform monitor, sampled on the falling clk edge.
   int clr_req = 0;
   int clr_seen = 0;
   int cs_low, pulses, hi_min, hi_max, lo_min, lo_max, hi_run, lo_run;
   int rx_cnt, rxv_long, viol, cs_falls, gap_run, last_gap;
   logic [7:0] rx_last;
   logic [7:0] rxq[$];
   logic p_sck, p_cs, p_mosi, p_rxv;

   always @(negedge clk) begin
      if (clr_req != clr_seen) begin
         clr_seen <= clr_req;
         cs_low <= 0; pulses <= 0; hi_min <= 255; hi_max <= 0; lo_min <= 255; lo_max <= 0;
         hi_run <= 0; lo_run <= 0; rx_cnt <= 0; rxv_long <= 0; viol <= 0;
         cs_falls <= 0; gap_run <= 0; last_gap <= 0; rx_last <= 8'h00;
         rxq.delete();
      end else begin
         if (!m_cs_n) cs_low <= cs_low + 1;
         if (!m_cs_n && p_cs) begin
            cs_falls <= cs_falls + 1;
            last_gap <= gap_run;
         end
         if (m_cs_n) gap_run <= p_cs ? gap_run + 1 : 1;
         if (m_sck && !p_sck) begin
            pulses <= pulses + 1;
            hi_run <= 1;
            if (lo_run < lo_min) lo_min <= lo_run;
            if (lo_run > lo_max) lo_max <= lo_run;
         end else if (m_sck) begin
            hi_run <= hi_run + 1;
         end
         if (!m_sck && p_sck) begin
            if (hi_run < hi_min) hi_min <= hi_run;
            if (hi_run > hi_max) hi_max <= hi_run;
         end
         if (m_cs_n || m_sck) lo_run <= 0;
         else                 lo_run <= lo_run + 1;
         if (m_rxv) begin
            rx_cnt  <= rx_cnt + 1;
            rx_last <= m_rxd;
            rxq.push_back(m_rxd);
         end
         if (m_rxv && p_rxv) rxv_long <= rxv_long + 1;
         if ((m_mosi !== p_mosi) && m_sck && p_sck) viol <= viol + 1;
      end
      p_sck  <= m_sck;
      p_cs   <= m_cs_n;
      p_mosi <= m_mosi;
      p_rxv  <= m_rxv;
   end

   function automatic logic [15:0] q_at(input int i);
      if (i < rxq.size()) return {8'h00, rxq[i]};
      return 16'hDEAD;
   endfunction

   task automatic mon_clear();
      clr_req++;
      repeat (2) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic l, input logic keep);
      int n;
      @(negedge clk);
      d_data = d; d_last = l; d_valid = 1'b1;
      n = 0;
      while (m_ready !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (!keep) d_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((m_busy !== 1'b0 || m_cs_n !== 1'b1) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) chk("idle_timeout", 0, 1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hold_bad;
      logic [7:0] seq [4];
      seq[0] = 8'h3A; seq[1] = 8'hC5; seq[2] = 8'h7E; seq[3] = 8'h81;
      sel = 1'b0; miso_mode = 2'd0; slv_pat = 8'h00;
      d_data = 8'h00; d_valid = 1'b0; d_last = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_cs_n", cs2, 1);
      chk("rst_sck", sck2, 0);
      chk("rst_mosi", mosi2, 0);
      chk("rst_ready", hif2.tx_ready, 0);
      chk("rst_busy", hif2.busy, 0);
      chk("rst_rxv", hif2.rx_valid, 0);
      chk("rst_rxd", hif2.rx_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", hif2.tx_ready, 1);
      chk("ready_after_rst_div1", hif1.tx_ready, 1);

      // single byte, loopback
      mon_clear();
      send(8'hA5, 1'b1, 1'b0);
      chk("acc_cs_n", cs2, 0);
      chk("acc_busy", hif2.busy, 1);
      chk("acc_mosi", mosi2, 1);
      chk("acc_ready", hif2.tx_ready, 0);
      wait_idle();
      chk("a5_cs_low", cs_low, 34);
      chk("a5_pulses", pulses, 8);
      chk("a5_hi_min", hi_min, 2);
      chk("a5_hi_max", hi_max, 2);
      chk("a5_lo_min", lo_min, 2);
      chk("a5_lo_max", lo_max, 2);
      chk("a5_rx_cnt", rx_cnt, 1);
      chk("a5_rx_data", rx_last, 8'hA5);
      chk("a5_rxv_width", rxv_long, 0);
      chk("a5_mosi_stable", viol, 0);
      chk("a5_cs_falls", cs_falls, 1);
      chk("a5_mosi_idle", mosi2, 0);

      // DIV=1, three bytes, miso tied low
      sel = 1'b1;
      mon_clear();
      send(8'h01, 1'b0, 1'b1);
      send(8'h80, 1'b0, 1'b1);
      send(8'hFF, 1'b1, 1'b0);
      wait_idle();
      chk("d1_cs_falls", cs_falls, 1);
      chk("d1_rx_cnt", rx_cnt, 3);
      chk("d1_rx0", q_at(0), 16'h0000);
      chk("d1_rx1", q_at(1), 16'h0000);
      chk("d1_rx2", q_at(2), 16'h0000);
      chk("d1_pulses", pulses, 24);
      chk("d1_cs_low", cs_low, 51);
      chk("d1_hi_max", hi_max, 1);
      chk("d1_mosi_stable", viol, 0);

      // HOLD stall with patterned responder
      sel = 1'b0; miso_mode = 2'd2; slv_pat = 8'h3C;
      mon_clear();
      send(8'h11, 1'b0, 1'b0);
      n = 0;
      while (hif2.tx_ready !== 1'b1 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) chk("hold_timeout", 0, 1);
      hold_bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (cs2 !== 1'b0 || sck2 !== 1'b0 || hif2.tx_ready !== 1'b1 || hif2.busy !== 1'b1)
            hold_bad++;
      end
      chk("hold_rx_cnt", rx_cnt, 1);
      chk("hold_stable", hold_bad, 0);
      send(8'h22, 1'b1, 1'b0);
      wait_idle();
      chk("hold_rx_total", rx_cnt, 2);
      chk("hold_rx0", q_at(0), 16'h003C);
      chk("hold_rx1", q_at(1), 16'h003C);
      chk("hold_cs_falls", cs_falls, 1);
      chk("hold_pulses", pulses, 16);

      // reset mid-byte
      miso_mode = 2'd0;
      mon_clear();
      send(8'h55, 1'b1, 1'b0);
      n = 0;
      while (pulses < 4 && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (n >= LIMIT) chk("midbyte_timeout", 0, 1);
      chk("midbyte_active", cs2, 0);
      rst = 1'b1;
      #1;
      chk("mrst_cs_n", cs2, 1);
      chk("mrst_sck", sck2, 0);
      chk("mrst_busy", hif2.busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("mrst_no_rxv", rx_cnt, 0);
      mon_clear();
      send(8'h55, 1'b1, 1'b0);
      wait_idle();
      chk("post_rst_rx_cnt", rx_cnt, 1);
      chk("post_rst_rx", rx_last, 8'h55);
      chk("post_rst_pulses", pulses, 8);
      chk("post_rst_cs_low", cs_low, 34);

      // back-to-back single-byte transactions
      mon_clear();
      send(8'h0F, 1'b1, 1'b1);
      send(8'hF0, 1'b1, 1'b0);
      wait_idle();
      chk("b2b_gap", last_gap, EXP_GAP);
      chk("b2b_cs_falls", cs_falls, 2);
      chk("b2b_rx0", q_at(0), 16'h000F);
      chk("b2b_rx1", q_at(1), 16'h00F0);

      // tx_valid held high across a multi-byte transaction
      mon_clear();
      for (int i = 0; i < 4; i++) send(seq[i], (i == 3), (i != 3));
      wait_idle();
      chk("str_rx_cnt", rx_cnt, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("str_rx%0d", i), q_at(i), {8'h00, seq[i]});
      chk("str_pulses", pulses, 32);
      chk("str_cs_falls", cs_falls, 1);
      chk("str_mosi_stable", viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
